// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the UART boot loader: FSM states, status bytes
// and the byte-index width used by the word assembler.
package prog_loader_pkg;

   typedef enum logic [1:0] {
      S_LEN,
      S_DATA,
      S_ACK,
      S_DONE
   } state_t;

   localparam logic [7:0] ACK_OK_BYTE  = 8'hAA;
   localparam logic [7:0] ACK_OVF_BYTE = 8'hEE;
   localparam int         BIDX_W       = 2;

endpackage

// File: rtl/prog_loader_byte_to_word.sv
// Assembles four popped bytes into a little-endian 32-bit word; word_valid
// is raised combinationally in the cycle the fourth byte is popped.
module byte_to_word
   import prog_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        pop,
   input  logic [7:0]  data,
   output logic [31:0] word,
   output logic        word_valid
);

   logic [BIDX_W-1:0] idx;
   logic [23:0]       low;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         idx <= '0;
         low <= '0;
      end else if (pop) begin
         idx <= idx + 1'b1;
         case (idx)
            2'd0:    low[7:0]   <= data;
            2'd1:    low[15:8]  <= data;
            2'd2:    low[23:16] <= data;
            default: ;
         endcase
      end
   end

   // The top byte is taken straight from the bus so the word is ready in the pop cycle.
   assign word       = {data, low};
   assign word_valid = pop && (&idx);

endmodule

// File: rtl/prog_loader.sv
// UART boot loader: reads a 32-bit word count then that many little-endian words
// into program RAM, holds the core in reset, and reports a status byte when done.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int         MEM     = 17,
   parameter logic [7:0] ACK_OK  = ACK_OK_BYTE,
   parameter logic [7:0] ACK_OVF = ACK_OVF_BYTE
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic [7:0]     rdata,
   input  logic           rx_ready,
   output logic           next,
   output logic [7:0]     sdata,
   output logic           tx_ready,
   output logic           prog_we,
   output logic [MEM-3:0] prog_addr,
   output logic [31:0]    prog_din,
   output logic           done,
   output logic           core_rstn
);

   localparam int              AW       = MEM - 2;
   localparam logic [32:0]     DEPTH    = 33'd1 << AW;
   localparam logic [AW-1:0]   ADDR_MAX = '1;

   state_t        state_q, state_d;
   logic          next_q;
   logic [31:0]   word;
   logic          word_valid;
   logic [31:0]   len_q;
   logic [31:0]   cnt_q;
   logic          ovf_q;
   logic          last_q;
   logic          consumed_q;
   logic          fits;

   // Popping only every other cycle lets the RX buffer's registered empty flag settle.
   assign next = rstn && rx_ready && !next_q && (state_q == S_LEN || state_q == S_DATA);

   byte_to_word u_b2w (
      .clk        (clk),
      .rstn       (rstn),
      .pop        (next),
      .data       (rdata),
      .word       (word),
      .word_valid (word_valid)
   );

   assign fits      = {1'b0, cnt_q} < DEPTH;
   assign prog_addr = fits ? cnt_q[AW-1:0] : ADDR_MAX;
   assign tx_ready  = (state_q == S_ACK);
   assign sdata     = tx_ready ? (ovf_q ? ACK_OVF : ACK_OK) : 8'h00;
   assign done      = (state_q == S_DONE);
   assign core_rstn = rstn & done;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_LEN:   if (word_valid) state_d = (word == 32'd0) ? S_ACK : S_DATA;
         S_DATA:  if (last_q)     state_d = S_ACK;
         S_ACK:   state_d = S_DONE;
         S_DONE:  state_d = S_DONE;
         default: state_d = S_LEN;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= S_LEN;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         next_q     <= 1'b0;
         len_q      <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         last_q     <= 1'b0;
         consumed_q <= 1'b0;
         prog_we    <= 1'b0;
         prog_din   <= '0;
      end else begin
         next_q     <= next;
         prog_we    <= 1'b0;
         consumed_q <= 1'b0;
         if (word_valid && state_q == S_LEN) begin
            len_q <= word;
            ovf_q <= {1'b0, word} > DEPTH;
         end
         if (word_valid && state_q == S_DATA) begin
            prog_we    <= fits;
            prog_din   <= word;
            consumed_q <= 1'b1;
            last_q     <= (cnt_q + 32'd1 == len_q);
         end
         // The address advances after the write cycle so prog_addr is stable during prog_we.
         if (consumed_q) cnt_q <= cnt_q + 32'd1;
         if (state_q == S_ACK) last_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a full-depth instance and a 4-word instance,
// each fed by a small RX-buffer model, with write and status logs checked.
module tb_prog_loader;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;

   logic [7:0]  rdata_a = 8'h00, rdata_b = 8'h00;
   logic        rx_ready_a = 1'b0, rx_ready_b = 1'b0;
   logic        next_a, next_b;
   logic [7:0]  sdata_a, sdata_b;
   logic        tx_ready_a, tx_ready_b;
   logic        prog_we_a, prog_we_b;
   logic [14:0] prog_addr_a;
   logic [1:0]  prog_addr_b;
   logic [31:0] prog_din_a, prog_din_b;
   logic        done_a, done_b;
   logic        core_rstn_a, core_rstn_b;

   logic [7:0]  qa[$], qb[$], ta[$], tb_q[$];
   wr_t         wa[$], wb[$];
   int          pops_a = 0, pops_b = 0, cyc = 0, viol = 0, last_pop_a = 0;
   bit          pend_a = 0, pend_b = 0, prev_a = 0, prev_b = 0;
   int          n_checks = 0, n_pass = 0;

   prog_loader #(.MEM(17)) dut_a (
      .clk(clk), .rstn(rstn), .rdata(rdata_a), .rx_ready(rx_ready_a), .next(next_a),
      .sdata(sdata_a), .tx_ready(tx_ready_a), .prog_we(prog_we_a), .prog_addr(prog_addr_a),
      .prog_din(prog_din_a), .done(done_a), .core_rstn(core_rstn_a)
   );

   prog_loader #(.MEM(4)) dut_b (
      .clk(clk), .rstn(rstn), .rdata(rdata_b), .rx_ready(rx_ready_b), .next(next_b),
      .sdata(sdata_b), .tx_ready(tx_ready_b), .prog_we(prog_we_b), .prog_addr(prog_addr_b),
      .prog_din(prog_din_b), .done(done_b), .core_rstn(core_rstn_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // RX buffer model: pop after the capturing edge, then present the new head byte.
   always @(posedge clk) begin
      cyc++;
      #1;
      if (pend_a) begin
         if (qa.size() != 0) void'(qa.pop_front());
         pops_a++;
         last_pop_a = cyc;
         pend_a = 0;
      end
      if (pend_b) begin
         if (qb.size() != 0) void'(qb.pop_front());
         pops_b++;
         pend_b = 0;
      end
      rx_ready_a = (qa.size() != 0);
      rdata_a    = rx_ready_a ? qa[0] : 8'h00;
      rx_ready_b = (qb.size() != 0);
      rdata_b    = rx_ready_b ? qb[0] : 8'h00;
   end

   always @(negedge clk) begin
      pend_a = next_a;
      pend_b = next_b;
      if (next_a && prev_a) viol++;
      if (next_b && prev_b) viol++;
      prev_a = next_a;
      prev_b = next_b;
      if (prog_we_a) wa.push_back('{32'(prog_addr_a), prog_din_a});
      if (prog_we_b) wb.push_back('{32'(prog_addr_b), prog_din_b});
      if (tx_ready_a) ta.push_back(sdata_a);
      if (tx_ready_b) tb_q.push_back(sdata_b);
   end

   task automatic push_word(input bit sel, input logic [31:0] w);
      for (int i = 0; i < 4; i++) begin
         if (sel) qb.push_back(w[8*i +: 8]);
         else     qa.push_back(w[8*i +: 8]);
      end
   endtask

   task automatic check_idle_a(input string tag);
      check({tag, ".next"},      64'(next_a),      64'd0);
      check({tag, ".tx_ready"},  64'(tx_ready_a),  64'd0);
      check({tag, ".prog_we"},   64'(prog_we_a),   64'd0);
      check({tag, ".prog_addr"}, 64'(prog_addr_a), 64'd0);
      check({tag, ".prog_din"},  64'(prog_din_a),  64'd0);
      check({tag, ".sdata"},     64'(sdata_a),     64'd0);
      check({tag, ".done"},      64'(done_a),      64'd0);
      check({tag, ".core_rstn"}, 64'(core_rstn_a), 64'd0);
   endtask

   task automatic apply_reset(input string tag);
      rstn = 1'b0;
      #1;
      check_idle_a(tag);
      qa.delete(); qb.delete(); wa.delete(); wb.delete(); ta.delete(); tb_q.delete();
      pops_a = 0;
      pops_b = 0;
      repeat (2) @(posedge clk);
      #2;
      rstn = 1'b1;
   endtask

   task automatic wait_done(input bit sel, input string tag);
      int k = 0;
      while (!(sel ? done_b : done_a) && k < 600) begin
         @(negedge clk);
         k++;
      end
      check(tag, 64'(sel ? done_b : done_a), 64'd1);
   endtask

   task automatic check_two_words(input string tag);
      check({tag, ".nwr"}, 64'(wa.size()), 64'd2);
      if (wa.size() >= 2) begin
         check({tag, ".a0"}, 64'(wa[0].addr), 64'd0);
         check({tag, ".d0"}, 64'(wa[0].data), 64'h0000_0013);
         check({tag, ".a1"}, 64'(wa[1].addr), 64'd1);
         check({tag, ".d1"}, 64'(wa[1].data), 64'h0010_0093);
      end
      check({tag, ".ntx"}, 64'(ta.size()), 64'd1);
      if (ta.size() != 0) check({tag, ".ack"}, 64'(ta[0]), 64'hAA);
   endtask

   initial begin
      int k;
      int lat;
      #2;
      apply_reset("rst0");

      // Two-word program, whole stream queued so rx_ready stays high throughout.
      push_word(0, 32'd2);
      push_word(0, 32'h0000_0013);
      push_word(0, 32'h0010_0093);
      wait_done(0, "t1.done");
      check_two_words("t1");
      check("t1.core_rstn", 64'(core_rstn_a), 64'd1);
      check("t1.pops", 64'(pops_a), 64'd12);
      check("t1.addr_after", 64'(prog_addr_a), 64'd2);

      // A byte arriving after completion must stay in the RX buffer.
      qa.push_back(8'h55);
      repeat (10) @(negedge clk);
      check("t6.pops", 64'(pops_a), 64'd12);
      check("t6.left", 64'(qa.size()), 64'd1);
      check("t6.done", 64'(done_a), 64'd1);

      // Reset after the header and two data bytes, then resend everything.
      apply_reset("rst1");
      push_word(0, 32'd2);
      push_word(0, 32'h0000_0013);
      push_word(0, 32'h0010_0093);
      k = 0;
      while (pops_a < 6 && k < 200) begin
         @(posedge clk);
         #2;
         k++;
      end
      check("t5.pops", 64'(pops_a), 64'd6);
      check("t5.rx_pending", 64'(rx_ready_a), 64'd1);
      apply_reset("t5.mid");
      push_word(0, 32'd2);
      push_word(0, 32'h0000_0013);
      push_word(0, 32'h0010_0093);
      wait_done(0, "t5.done");
      check_two_words("t5");

      // Empty program: status straight after the header.
      apply_reset("rst2");
      push_word(0, 32'd0);
      wait_done(0, "t2.done");
      lat = cyc - last_pop_a + 1;
      check("t2.lat_le3", 64'(lat <= 3), 64'd1);
      check("t2.nwr", 64'(wa.size()), 64'd0);
      check("t2.ntx", 64'(ta.size()), 64'd1);
      if (ta.size() != 0) check("t2.ack", 64'(ta[0]), 64'hAA);

      // Four-word memory, five words announced: overflow status, fifth word dropped.
      apply_reset("rst3");
      push_word(1, 32'd5);
      for (int i = 0; i < 5; i++) push_word(1, 32'hA0B0_C0D0 + 32'(i));
      wait_done(1, "t3.done");
      check("t3.nwr", 64'(wb.size()), 64'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < wb.size()) begin
            check($sformatf("t3.a%0d", i), 64'(wb[i].addr), 64'(i));
            check($sformatf("t3.d%0d", i), 64'(wb[i].data), 64'(32'hA0B0_C0D0 + 32'(i)));
         end
      end
      check("t3.pops", 64'(pops_b), 64'd24);
      check("t3.ntx", 64'(tb_q.size()), 64'd1);
      if (tb_q.size() != 0) check("t3.ack", 64'(tb_q[0]), 64'hEE);
      check("t3.addr_sat", 64'(prog_addr_b), 64'd3);
      check("t3.core_rstn", 64'(core_rstn_b), 64'd1);

      check("pop_spacing", 64'(viol), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
